// File: rtl/cae_pers_pkg.sv
// Shared types and constants for the PDES personality controller.
package cae_pers_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LAUNCH   = 2'd1,
    ST_RUNNING  = 2'd2,
    ST_FINISHED = 2'd3
  } state_e;

  // AEG register map
  localparam int AEG_ADDR     = 0;
  localparam int AEG_SIM_END  = 1;
  localparam int AEG_NUM_INIT = 2;
  localparam int AEG_LP_MASK  = 3;
  localparam int AEG_TIMEOUT  = 4;
  localparam int AEG_GVT      = 5;
  localparam int AEG_CYCLES   = 6;
  localparam int AEG_STATUS   = 7;

  // CSR addresses
  localparam logic [15:0] CSR_STATUS = 16'h0;
  localparam logic [15:0] CSR_GVT    = 16'h1;
  localparam logic [15:0] CSR_CYCLES = 16'h2;

  // Dispatch opcodes
  localparam logic [4:0] OP_START = 5'd0;
  localparam logic [4:0] OP_ABORT = 5'd1;

  // Exception bit positions
  localparam int EXC_UNIMPL  = 0;
  localparam int EXC_BAD_IDX = 1;
  localparam int EXC_TIMEOUT = 2;
  localparam int EXC_ABORT   = 3;

  // Status word layout shared by AEG7 and CSR 0x0
  function automatic logic [63:0] status_word(input logic aborted, input logic timed_out,
                                              input state_e st);
    return {60'b0, aborted, timed_out, st};
  endfunction

endpackage

// File: rtl/cae_gvt_min.sv
// Combinational minimum-reduction tree over the per-engine GVT results.
// Leaves beyond NUM_ENG are padded with all-ones so they never win.
module cae_gvt_min #(
  parameter int NUM_ENG = 4,
  parameter int GVT_W   = 16
) (
  input  logic [NUM_ENG*GVT_W-1:0] gvt_flat,
  output logic [GVT_W-1:0]         gvt_min
);

  localparam int LVLS   = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 0;
  localparam int LEAVES = 1 << LVLS;

  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    logic [(LEAVES>>l)-1:0][GVT_W-1:0] v;
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < LEAVES; i++) begin : g_n
        if (i < NUM_ENG) begin : g_eng
          assign v[i] = gvt_flat[i*GVT_W +: GVT_W];
        end else begin : g_pad
          assign v[i] = '1;
        end
      end
    end else begin : g_node
      for (genvar i = 0; i < (LEAVES>>l); i++) begin : g_n
        assign v[i] = (g_lvl[l-1].v[2*i] <= g_lvl[l-1].v[2*i+1]) ?
                      g_lvl[l-1].v[2*i] : g_lvl[l-1].v[2*i+1];
      end
    end
  end

  assign gvt_min = g_lvl[LVLS].v[0];

endmodule

// File: rtl/cae_pers_ctl.sv
// Dispatch/run controller for the PDES personality: AEG file, caep00/caep01
// decode, engine launch/supervision, GVT min-reduction and cycle counting.
// Optional watchdog enabled by defining CAE_PERS_CTL_TIMEOUT_EN.
module cae_pers_ctl
  import cae_pers_pkg::*;
#(
  parameter int NUM_AEG   = 8,
  parameter int AEG_IDX_W = 3,
  parameter int NUM_ENG   = 4,
  parameter int GVT_W     = 16
) (
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic                     disp_inst_vld,
  input  logic [4:0]               disp_inst,
  input  logic [17:0]              disp_aeg_idx,
  input  logic                     disp_aeg_rd,
  input  logic                     disp_aeg_wr,
  input  logic [63:0]              disp_aeg_wr_data,
  output logic [17:0]              disp_aeg_cnt,
  output logic [15:0]              disp_exception,
  output logic                     disp_idle,
  output logic                     disp_stall,
  output logic                     disp_rtn_data_vld,
  output logic [63:0]              disp_rtn_data,
  input  logic                     csr_rd_vld,
  input  logic [15:0]              csr_address,
  output logic                     csr_rd_ack,
  output logic [63:0]              csr_rd_data,
  input  logic [3:0]               i_aeid,
  output logic [NUM_AEG*64-1:0]    aeg_flat,
  output logic                     eng_rst_n,
  output logic                     eng_start,
  input  logic [NUM_ENG-1:0]       eng_done,
  input  logic [NUM_ENG*GVT_W-1:0] eng_gvt
);

  state_e                   state_q, state_d;
  logic                     start_pend_q, start_pend_d;
  logic                     eng_start_q, eng_start_d;
  logic                     eng_rst_n_q, eng_rst_n_d;
  logic                     aborted_q, aborted_d;
  logic                     timed_out_q, timed_out_d;
  logic                     gvt_upd_q, gvt_upd_d;
  logic                     tmo_hit, tmo_fire;
  logic [63:0]              cyc_q, cyc_d;
  logic [NUM_AEG-1:0][63:0] aeg_q, aeg_d;
  logic [GVT_W-1:0]         gvt_min, gvt_min_q;
  logic [3:0]               exc_q, exc_d;
  logic                     rtn_vld_q;
  logic [63:0]              rtn_data_q, rtn_data_d;
  logic                     csr_ack_q;
  logic [63:0]              csr_data_q, csr_data_d;

  logic                     is_start, is_abort, idx_ok, all_done;
  logic [AEG_IDX_W-1:0]     idx_lo;

  assign is_start = disp_inst_vld && (disp_inst == OP_START);
  assign is_abort = disp_inst_vld && (disp_inst == OP_ABORT);
  assign idx_ok   = disp_aeg_idx < 18'(NUM_AEG);
  assign idx_lo   = disp_aeg_idx[AEG_IDX_W-1:0];
  assign all_done = &eng_done;

`ifdef CAE_PERS_CTL_TIMEOUT_EN
  assign tmo_hit = (aeg_q[AEG_TIMEOUT] != 64'd0) && (cyc_q == aeg_q[AEG_TIMEOUT]);
`else
  assign tmo_hit = 1'b0;
`endif

  cae_gvt_min #(.NUM_ENG(NUM_ENG), .GVT_W(GVT_W)) u_gvt_min (
    .gvt_flat (eng_gvt),
    .gvt_min  (gvt_min)
  );

  // Next-state and run-flag logic; abort beats timeout beats completion
  always_comb begin
    state_d     = state_q;
    aborted_d   = aborted_q;
    timed_out_d = timed_out_q;
    gvt_upd_d   = gvt_upd_q;
    tmo_fire    = 1'b0;
    case (state_q)
      ST_IDLE:     if (start_pend_q) state_d = ST_LAUNCH;
      ST_LAUNCH: begin
        state_d     = ST_RUNNING;
        aborted_d   = 1'b0;
        timed_out_d = 1'b0;
        gvt_upd_d   = 1'b0;
      end
      ST_RUNNING: begin
        if (is_abort) begin
          state_d   = ST_FINISHED;
          aborted_d = 1'b1;
        end else if (tmo_hit) begin
          state_d     = ST_FINISHED;
          timed_out_d = 1'b1;
          tmo_fire    = 1'b1;
        end else if (all_done) begin
          state_d   = ST_FINISHED;
          gvt_upd_d = 1'b1;
        end else if (i_aeid != 4'd0) begin
          state_d = ST_FINISHED;
        end
      end
      ST_FINISHED: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    // caep00 is only taken while idle; the pending flag is consumed by LAUNCH
    start_pend_d = start_pend_q ? 1'b0 : (is_start && (state_q == ST_IDLE));
    eng_start_d  = (state_d == ST_LAUNCH) && (i_aeid == 4'd0);
    eng_rst_n_d  = (state_d == ST_RUNNING);
  end

  // FSM and registered engine controls
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      start_pend_q <= 1'b0;
      eng_start_q  <= 1'b0;
      eng_rst_n_q  <= 1'b0;
      aborted_q    <= 1'b0;
      timed_out_q  <= 1'b0;
      gvt_upd_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_pend_q <= start_pend_d;
      eng_start_q  <= eng_start_d;
      eng_rst_n_q  <= eng_rst_n_d;
      aborted_q    <= aborted_d;
      timed_out_q  <= timed_out_d;
      gvt_upd_q    <= gvt_upd_d;
    end
  end

  // Cycle counter, AEG file updates (dispatch write applied last so it wins)
  always_comb begin
    cyc_d = cyc_q;
    if (state_q == ST_LAUNCH) cyc_d = 64'd0;
    else if (state_q == ST_RUNNING && cyc_q != '1) cyc_d = cyc_q + 64'd1;

    aeg_d = aeg_q;
    if (state_q == ST_FINISHED) begin
      if (gvt_upd_q) aeg_d[AEG_GVT] = 64'(gvt_min_q);
      aeg_d[AEG_CYCLES] = cyc_q;
      aeg_d[AEG_STATUS] = status_word(aborted_q, timed_out_q, ST_IDLE);
    end
    if (disp_aeg_wr && idx_ok) begin
      for (int k = 0; k < NUM_AEG; k++)
        if (idx_lo == AEG_IDX_W'(k)) aeg_d[k] = disp_aeg_wr_data;
    end
  end

  // Read returns, CSR returns and exception sources
  always_comb begin
    rtn_data_d = 64'd0;
    if (disp_aeg_rd && idx_ok) begin
      for (int k = 0; k < NUM_AEG; k++)
        if (idx_lo == AEG_IDX_W'(k)) rtn_data_d = aeg_q[k];
    end
    csr_data_d = 64'd0;
    if (csr_rd_vld) begin
      case (csr_address)
        CSR_STATUS: csr_data_d = status_word(aborted_q, timed_out_q, state_q);
        CSR_GVT:    csr_data_d = aeg_q[AEG_GVT];
        CSR_CYCLES: csr_data_d = cyc_q;
        default:    csr_data_d = 64'd0;
      endcase
    end
    exc_d              = 4'd0;
    exc_d[EXC_UNIMPL]  = disp_inst_vld && (disp_inst > OP_ABORT);
    exc_d[EXC_BAD_IDX] = (disp_aeg_rd || disp_aeg_wr) && !idx_ok;
    exc_d[EXC_TIMEOUT] = tmo_fire;
    exc_d[EXC_ABORT]   = is_abort && (state_q == ST_RUNNING);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      cyc_q      <= 64'd0;
      aeg_q      <= '0;
      gvt_min_q  <= '0;
      exc_q      <= 4'd0;
      rtn_vld_q  <= 1'b0;
      rtn_data_q <= 64'd0;
      csr_ack_q  <= 1'b0;
      csr_data_q <= 64'd0;
    end else begin
      cyc_q      <= cyc_d;
      aeg_q      <= aeg_d;
      gvt_min_q  <= gvt_min;
      exc_q      <= exc_d;
      rtn_vld_q  <= disp_aeg_rd;
      rtn_data_q <= rtn_data_d;
      csr_ack_q  <= csr_rd_vld;
      csr_data_q <= csr_data_d;
    end
  end

  assign disp_aeg_cnt      = 18'(NUM_AEG);
  assign disp_exception    = {12'd0, exc_q};
  assign disp_idle         = (state_q == ST_IDLE) && !start_pend_q;
  assign disp_stall        = (state_q != ST_IDLE) || is_start || start_pend_q;
  assign disp_rtn_data_vld = rtn_vld_q;
  assign disp_rtn_data     = rtn_data_q;
  assign csr_rd_ack        = csr_ack_q;
  assign csr_rd_data       = csr_data_q;
  assign aeg_flat          = aeg_q;
  assign eng_rst_n         = eng_rst_n_q;
  assign eng_start         = eng_start_q;

endmodule

// File: tb/tb_cae_pers_ctl.sv
// Self-checking bench for cae_pers_ctl: directed sequence with randomized
// data, checked against a simple AEG/GVT/cycle model kept here.
module tb_cae_pers_ctl;

  localparam int NAEG = 8;
  localparam int NENG = 4;
  localparam int GW   = 16;

  logic                 clk = 1'b0;
  logic                 i_reset;
  logic                 disp_inst_vld;
  logic [4:0]           disp_inst;
  logic [17:0]          disp_aeg_idx;
  logic                 disp_aeg_rd, disp_aeg_wr;
  logic [63:0]          disp_aeg_wr_data;
  logic [17:0]          disp_aeg_cnt;
  logic [15:0]          disp_exception;
  logic                 disp_idle, disp_stall, disp_rtn_data_vld;
  logic [63:0]          disp_rtn_data;
  logic                 csr_rd_vld;
  logic [15:0]          csr_address;
  logic                 csr_rd_ack;
  logic [63:0]          csr_rd_data;
  logic [3:0]           i_aeid;
  logic [NAEG*64-1:0]   aeg_flat;
  logic                 eng_rst_n, eng_start;
  logic [NENG-1:0]      eng_done;
  logic [NENG*GW-1:0]   eng_gvt;

  int          nchk = 0;
  int          nerr = 0;
  logic [63:0] model_aeg [NAEG];
  logic [15:0] gv [NENG];

  cae_pers_ctl #(.NUM_AEG(NAEG), .AEG_IDX_W(3), .NUM_ENG(NENG), .GVT_W(GW)) dut (
    .clk(clk), .i_reset(i_reset),
    .disp_inst_vld(disp_inst_vld), .disp_inst(disp_inst), .disp_aeg_idx(disp_aeg_idx),
    .disp_aeg_rd(disp_aeg_rd), .disp_aeg_wr(disp_aeg_wr), .disp_aeg_wr_data(disp_aeg_wr_data),
    .disp_aeg_cnt(disp_aeg_cnt), .disp_exception(disp_exception),
    .disp_idle(disp_idle), .disp_stall(disp_stall),
    .disp_rtn_data_vld(disp_rtn_data_vld), .disp_rtn_data(disp_rtn_data),
    .csr_rd_vld(csr_rd_vld), .csr_address(csr_address),
    .csr_rd_ack(csr_rd_ack), .csr_rd_data(csr_rd_data),
    .i_aeid(i_aeid), .aeg_flat(aeg_flat),
    .eng_rst_n(eng_rst_n), .eng_start(eng_start),
    .eng_done(eng_done), .eng_gvt(eng_gvt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_aeg(input string tag);
    for (int k = 0; k < NAEG; k++)
      chk($sformatf("%s_aeg%0d", tag, k), aeg_flat[64*k +: 64], model_aeg[k]);
  endtask

  task automatic wr_aeg(input int idx, input logic [63:0] data);
    disp_aeg_wr = 1'b1; disp_aeg_idx = 18'(idx); disp_aeg_wr_data = data;
    step();
    disp_aeg_wr = 1'b0;
    if (idx < NAEG) model_aeg[idx] = data;
    chk($sformatf("wr%0d_exc", idx), 64'(disp_exception), (idx < NAEG) ? 64'd0 : 64'd2);
  endtask

  task automatic rd_aeg(input int idx);
    disp_aeg_rd = 1'b1; disp_aeg_idx = 18'(idx);
    step();
    disp_aeg_rd = 1'b0;
    chk($sformatf("rd%0d_vld", idx), 64'(disp_rtn_data_vld), 64'd1);
    chk($sformatf("rd%0d_data", idx), disp_rtn_data, (idx < NAEG) ? model_aeg[idx] : 64'd0);
    chk($sformatf("rd%0d_exc", idx), 64'(disp_exception), (idx < NAEG) ? 64'd0 : 64'd2);
  endtask

  task automatic csr_rd(input logic [15:0] addr, input logic [63:0] exp);
    csr_rd_vld = 1'b1; csr_address = addr;
    step();
    csr_rd_vld = 1'b0;
    chk($sformatf("csr%0h_ack", addr), 64'(csr_rd_ack), 64'd1);
    chk($sformatf("csr%0h_data", addr), csr_rd_data, exp);
  endtask

  // caep00 and walk to the first RUNNING cycle (t+3)
  task automatic launch(input bit expect_start);
    disp_inst_vld = 1'b1; disp_inst = 5'd0;
    #1 chk("stall_on_req", 64'(disp_stall), 64'd1);
    step();                                     // t+1
    disp_inst_vld = 1'b0;
    #1 chk("idle_pending", 64'(disp_idle), 64'd0);
    step();                                     // t+2
    chk("eng_start_launch", 64'(eng_start), 64'(expect_start));
    chk("rst_n_launch", 64'(eng_rst_n), 64'd0);
    step();                                     // t+3
    chk("rst_n_running", 64'(eng_rst_n), 64'd1);
    chk("start_pulse_end", 64'(eng_start), 64'd0);
  endtask

  // Full run ending on all-done; optional caep01 in the same cycle
  task automatic run_eng(input bit abrt);
    int          r;
    logic [15:0] mn;
    r  = $urandom_range(2, 15);
    mn = 16'hFFFF;
    for (int i = 0; i < NENG; i++) if (gv[i] < mn) mn = gv[i];
    launch(1'b1);
    repeat (r) step();                          // cycle u; RUNNING cycles = r+1
    eng_done = '1;
    for (int i = 0; i < NENG; i++) eng_gvt[i*GW +: GW] = gv[i];
    if (abrt) begin disp_inst_vld = 1'b1; disp_inst = 5'd1; end
    step();                                     // u+1 FINISHED
    eng_done = '0; disp_inst_vld = 1'b0;
    chk("exc_abort", 64'(disp_exception), abrt ? 64'd8 : 64'd0);
    chk("rst_n_finished", 64'(eng_rst_n), 64'd0);
    step();                                     // u+2 IDLE
    chk("idle_after_run", 64'(disp_idle), 64'd1);
    if (!abrt) model_aeg[5] = 64'(mn);
    model_aeg[6] = 64'(r + 1);
    model_aeg[7] = abrt ? 64'h8 : 64'h0;
    chk_all_aeg(abrt ? "abort" : "done");
    csr_rd(16'h0, model_aeg[7]);
    csr_rd(16'h1, model_aeg[5]);
    csr_rd(16'h2, 64'(r + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; disp_inst_vld = 1'b0; disp_inst = '0; disp_aeg_idx = '0;
    disp_aeg_rd = 1'b0; disp_aeg_wr = 1'b0; disp_aeg_wr_data = '0;
    csr_rd_vld = 1'b0; csr_address = '0; i_aeid = 4'd0; eng_done = '0; eng_gvt = '0;
    for (int k = 0; k < NAEG; k++) model_aeg[k] = 64'd0;
    step(); step();

    // Reset state
    chk("rst_idle", 64'(disp_idle), 64'd1);
    chk("rst_stall", 64'(disp_stall), 64'd0);
    chk("rst_exc", 64'(disp_exception), 64'd0);
    chk("rst_rtn_vld", 64'(disp_rtn_data_vld), 64'd0);
    chk("rst_rtn_data", disp_rtn_data, 64'd0);
    chk("rst_csr_ack", 64'(csr_rd_ack), 64'd0);
    chk("rst_csr_data", csr_rd_data, 64'd0);
    chk("rst_eng_start", 64'(eng_start), 64'd0);
    chk("rst_eng_rst_n", 64'(eng_rst_n), 64'd0);
    chk("aeg_cnt", 64'(disp_aeg_cnt), 64'd8);
    chk_all_aeg("rst");
    i_reset = 1'b0;
    step();

    // AEG access, including out-of-range index
    wr_aeg(2, 64'h1234);
    rd_aeg(2);
    for (int k = 0; k < NAEG; k++) wr_aeg(k, {$urandom, $urandom});
    for (int k = NAEG - 1; k >= 0; k--) rd_aeg(k);
    wr_aeg(9, {$urandom, $urandom});
    rd_aeg(9);
    step();
    chk("exc_pulse_end", 64'(disp_exception), 64'd0);
    chk_all_aeg("after_wr");
`ifndef CAE_PERS_CTL_TIMEOUT_EN
    wr_aeg(4, 64'd3);   // plain register when the watchdog is absent
`else
    wr_aeg(4, 64'd0);
`endif

    // Runs to completion
    gv[0] = 16'd40; gv[1] = 16'd25; gv[2] = 16'd90; gv[3] = 16'd31;
    run_eng(1'b0);
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < NENG; i++) gv[i] = 16'($urandom_range(0, 65535));
      run_eng(1'b0);
    end

    // Abort coincident with completion
    for (int i = 0; i < NENG; i++) gv[i] = 16'($urandom_range(0, 100));
    run_eng(1'b1);

    // caep01 while idle is ignored
    disp_inst_vld = 1'b1; disp_inst = 5'd1;
    step();
    disp_inst_vld = 1'b0;
    chk("abort_idle_exc", 64'(disp_exception), 64'd0);
    chk("abort_idle_idle", 64'(disp_idle), 64'd1);

    // Non-zero AE never launches engines
    begin
      bit seen;
      i_aeid = 4'd3;
      launch(1'b0);                             // at t+3
      seen = eng_start;
      step(); seen |= eng_start;                // t+4
      step(); seen |= eng_start;                // t+5
      chk("aeid_no_start", 64'(seen), 64'd0);
      chk("aeid_idle", 64'(disp_idle), 64'd1);
      model_aeg[6] = 64'd1; model_aeg[7] = 64'd0;
      chk_all_aeg("aeid");
      i_aeid = 4'd0;
    end

`ifdef CAE_PERS_CTL_TIMEOUT_EN
    // Watchdog expiry
    begin
      bit found = 1'b0;
      wr_aeg(4, 64'd100);
      launch(1'b1);
      for (int i = 0; i < 400 && !found; i++) begin
        step();
        if (disp_exception[2]) found = 1'b1;
      end
      chk("tmo_exc", 64'(found), 64'd1);
      step();
      chk("tmo_idle", 64'(disp_idle), 64'd1);
      csr_rd(16'h0, 64'h4);
      chk("tmo_cycles", 64'(aeg_flat[6*64 +: 64] >= 64'd100), 64'd1);
      chk("tmo_gvt_kept", aeg_flat[5*64 +: 64], model_aeg[5]);
      wr_aeg(4, 64'd0);
      wr_aeg(6, 64'd0);
      model_aeg[7] = 64'h4;
    end
`endif

    // Unimplemented opcode and unmapped CSR
    disp_inst_vld = 1'b1; disp_inst = 5'($urandom_range(2, 31));
    step();
    disp_inst_vld = 1'b0;
    chk("unimpl_exc", 64'(disp_exception), 64'd1);
    csr_rd(16'h7, 64'd0);

    // Reset in the middle of a run
    launch(1'b1);
    step();
    #1 i_reset = 1'b1;
    #1;
    chk("midrst_rst_n", 64'(eng_rst_n), 64'd0);
    chk("midrst_idle", 64'(disp_idle), 64'd1);
    for (int k = 0; k < NAEG; k++) model_aeg[k] = 64'd0;
    chk_all_aeg("midrst");
    step();
    i_reset = 1'b0;
    disp_inst_vld = 1'b1; disp_inst = 5'd5;
    step();
    disp_inst_vld = 1'b0;
    chk("post_rst_unimpl", 64'(disp_exception), 64'd1);
    rd_aeg(2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
